// File: rtl/foo_arbiter_pkg.sv
// Shared types and defaults for the foo arbiter and its response FIFO.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package foo_arbiter_pkg;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_PIPE_LATENCY = 3;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DATA_W           = 32;

    // Tag ids are carried at a fixed width large enough for any sane
    // requester count; the arbiter zero-extends into it and slices back out.
    localparam int TAG_ID_W         = 8;

    // Width of a requester id; a single requester still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One slot of the tag delay line that shadows the external pipeline.
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/foo_resp_fifo.sv
// Generic register-array FIFO holding completed responses ({id, data}).
// Latency: a push is visible at the head on the next cycle (pop_vld = !empty).
// Backpressure: push is ignored when full unless a pop frees a slot that cycle.
module foo_resp_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 34,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop_vld & pop_rdy;
    assign do_push = push_vld & (!full | do_pop);

    assign pop_vld = !empty;
    // Head is forced to zero when empty so outputs are clean out of reset.
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy tracking; a simultaneous push and pop holds count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/foo_arbiter.sv
// Round-robin arbiter feeding a shared fixed-latency pipeline, with tag tracking and a response FIFO.
// Latency: issue to resp_valid is PIPE_LATENCY+1 cycles; grant is combinational from rr_ptr.
// Backpressure: issue stalls when FIFO entries plus in-flight work reach FIFO_DEPTH, so the FIFO never overflows.
module foo_arbiter
    import foo_arbiter_pkg::*;
#(
    parameter int  NUM_REQ      = DEF_NUM_REQ,
    parameter int  PIPE_LATENCY = DEF_PIPE_LATENCY,
    parameter int  FIFO_DEPTH   = DEF_FIFO_DEPTH,
    localparam int ID_W         = id_width(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_x,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [31:0]           pipe_x,
    output logic                  pipe_input_valid,
    input  logic [31:0]           pipe_out,
    input  logic                  pipe_output_valid,
    output logic                  pipe_rst_n,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic [ID_W-1:0]       resp_id,
    output logic                  err_unexpected
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_W = DATA_W + ID_W;

    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     occupancy;
    logic               can_issue;

    logic [NUM_REQ-1:0] req_hi;
    logic               grant_vld;
    logic [ID_W-1:0]    grant_idx;
    logic               issue;

    tag_t               tag_q [PIPE_LATENCY];
    tag_t               tag_in;
    tag_t               tag_out;
    logic               ret_vld;
    logic               tag_id_unused;

    logic [FIFO_W-1:0]  fifo_head;

    // The pipeline has a synchronous reset, so it simply follows ours.
    assign pipe_rst_n = ~rst;

    // Credit: everything issued but not yet popped counts against the FIFO.
    assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};
    assign can_issue = (occupancy < (CNT_W+1)'(FIFO_DEPTH));

    // Round-robin pick: lowest valid requester at or above rr_ptr, else lowest overall.
    always_comb begin
        req_hi    = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_hi[i] = req_valid[i] && (i >= int'(rr_ptr));
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
        if (|req_hi) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req_hi[i]) begin
                    grant_idx = ID_W'(i);
                end
            end
        end
    end

    // One-hot ready and operand mux; reset and missing credit suppress any grant.
    always_comb begin
        req_ready = '0;
        pipe_x    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vld && can_issue && !rst && (grant_idx == ID_W'(i))) begin
                req_ready[i] = 1'b1;
                pipe_x       = req_x[32*i +: 32];
            end
        end
    end

    assign pipe_input_valid = |(req_valid & req_ready);
    assign issue            = pipe_input_valid;

    // Advance the round-robin pointer past the requester just served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

    assign tag_in.valid = issue;
    assign tag_in.id    = TAG_ID_W'(grant_idx);

    // Tag delay line mirrors the pipeline depth so its tail lines up with pipe_output_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_out = tag_q[PIPE_LATENCY-1];
    assign ret_vld = pipe_output_valid & tag_out.valid;

    // Upper tag id bits are always zero; fold them into a sink so the tag stays width-generic.
    assign tag_id_unused = |(tag_out.id >> ID_W);

    // In-flight count: up on issue, down on a tagged return, unchanged when both happen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({issue, ret_vld})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // A result with no matching tag is dropped and latched as an error until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_unexpected <= 1'b0;
        end else if (pipe_output_valid && !tag_out.valid) begin
            err_unexpected <= 1'b1;
        end
    end

    foo_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_resp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (ret_vld),
        .push_dat ({tag_out.id[ID_W-1:0], pipe_out}),
        .pop_vld  (resp_valid),
        .pop_rdy  (resp_ready),
        .pop_dat  (fifo_head),
        .count    (fifo_count)
    );

    assign resp_data = fifo_head[DATA_W-1:0];
    assign resp_id   = fifo_head[DATA_W +: ID_W];

endmodule

// File: tb/tb_foo_arbiter.sv
// Bench for foo_arbiter with a behavioural 3-stage x+3 pipeline attached.
// Latency: pipeline model returns results 3 cycles after issue.
// Backpressure: resp_ready driven by the vectors and hand sequences.
module tb_foo_arbiter;
    import foo_arbiter_pkg::*;

    localparam logic [31:0] X0 = 32'h0000_0100;
    localparam logic [31:0] X1 = 32'h0000_0200;
    localparam logic [31:0] X2 = 32'h0000_0010;
    localparam logic [31:0] X3 = 32'hFFFF_FFFE;
    localparam logic [31:0] R0 = 32'h0000_0103;
    localparam logic [31:0] R1 = 32'h0000_0203;
    localparam logic [31:0] R2 = 32'h0000_0013;
    localparam logic [31:0] R3 = 32'h0000_0001;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_x;
    logic [3:0]   req_ready;
    logic [31:0]  pipe_x;
    logic         pipe_input_valid;
    logic [31:0]  pipe_out;
    logic         pipe_output_valid;
    logic         pipe_rst_n;
    logic         resp_valid;
    logic         resp_ready;
    logic [31:0]  resp_data;
    logic [1:0]   resp_id;
    logic         err_unexpected;
    logic         force_pov;

    logic [2:0]   pv;
    logic [31:0]  pd [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    foo_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_x             (req_x),
        .req_ready         (req_ready),
        .pipe_x            (pipe_x),
        .pipe_input_valid  (pipe_input_valid),
        .pipe_out          (pipe_out),
        .pipe_output_valid (pipe_output_valid),
        .pipe_rst_n        (pipe_rst_n),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_data         (resp_data),
        .resp_id           (resp_id),
        .err_unexpected    (err_unexpected)
    );

    // Shared foo pipeline: three registered stages computing x+3, synchronous active-low reset.
    always @(posedge clk) begin
        if (!pipe_rst_n) begin
            pv    <= '0;
            pd[0] <= '0;
            pd[1] <= '0;
            pd[2] <= '0;
        end else begin
            pv    <= {pv[1:0], pipe_input_valid};
            pd[0] <= pipe_x + 32'd3;
            pd[1] <= pd[0];
            pd[2] <= pd[1];
        end
    end

    assign pipe_output_valid = pv[2] | force_pov;
    assign pipe_out          = pd[2];

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic        rr;
        logic [3:0]  e_ready;
        logic [31:0] e_px;
        logic        e_rvld;
        logic [1:0]  e_id;
        logic [31:0] e_data;
    } vec_t;

    vec_t vq [$];

    task automatic add(input logic r, input logic [3:0] rv, input logic rr,
                       input logic [3:0] e_ready, input logic [31:0] e_px,
                       input logic e_rvld, input logic [1:0] e_id, input logic [31:0] e_data);
        vec_t v;
        v.rst = r; v.rv = rv; v.rr = rr; v.e_ready = e_ready; v.e_px = e_px;
        v.e_rvld = e_rvld; v.e_id = e_id; v.e_data = e_data;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Hard stop in case something wedges the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int issues;
        int drained;
        int seen;
        logic [31:0] res [4];
        res[0] = R0; res[1] = R1; res[2] = R2; res[3] = R3;

        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        force_pov  = 1'b0;
        req_x      = {X3, X2, X1, X0};

        // Reset: no grants even with every requester asking.
        repeat (4) add(1, 4'hF, 1, 4'b0000, 32'h0, 0, 0, 32'h0);
        // Single request from requester 2: ready in cycle 0, response in cycle 4.
        add(0, 4'b0100, 1, 4'b0100, X2, 0, 0, 32'h0);
        repeat (3) add(0, 4'b0000, 1, 4'b0000, 32'h0, 0, 0, 32'h0);
        add(0, 4'b0000, 1, 4'b0000, 32'h0, 1, 2, R2);
        add(0, 4'b0000, 1, 4'b0000, 32'h0, 0, 0, 32'h0);
        // Requester 3 with x = 0xFFFF_FFFE: result wraps to 1.
        add(0, 4'b1000, 1, 4'b1000, X3, 0, 0, 32'h0);
        repeat (3) add(0, 4'b0000, 1, 4'b0000, 32'h0, 0, 0, 32'h0);
        add(0, 4'b0000, 1, 4'b0000, 32'h0, 1, 3, R3);
        add(0, 4'b0000, 1, 4'b0000, 32'h0, 0, 0, 32'h0);
        // Reset again so contention starts from rr_ptr = 0.
        repeat (4) add(1, 4'hF, 1, 4'b0000, 32'h0, 0, 0, 32'h0);
        // Full contention: four in a row, credit stall while four are outstanding, then 0 again.
        add(0, 4'hF, 1, 4'b0001, X0, 0, 0, 32'h0);
        add(0, 4'hF, 1, 4'b0010, X1, 0, 0, 32'h0);
        add(0, 4'hF, 1, 4'b0100, X2, 0, 0, 32'h0);
        add(0, 4'hF, 1, 4'b1000, X3, 0, 0, 32'h0);
        add(0, 4'hF, 1, 4'b0000, 32'h0, 1, 0, R0);
        add(0, 4'hF, 1, 4'b0001, X0, 1, 1, R1);
        add(0, 4'hF, 1, 4'b0010, X1, 1, 2, R2);
        add(0, 4'hF, 1, 4'b0100, X2, 1, 3, R3);
        add(0, 4'hF, 1, 4'b1000, X3, 0, 0, 32'h0);
        add(0, 4'hF, 1, 4'b0000, 32'h0, 1, 0, R0);
        add(0, 4'h0, 1, 4'b0000, 32'h0, 1, 1, R1);
        add(0, 4'h0, 1, 4'b0000, 32'h0, 1, 2, R2);
        add(0, 4'h0, 1, 4'b0000, 32'h0, 1, 3, R3);
        add(0, 4'h0, 1, 4'b0000, 32'h0, 0, 0, 32'h0);

        for (int k = 0; k < vq.size(); k++) begin
            tick();
            rst        = vq[k].rst;
            req_valid  = vq[k].rv;
            resp_ready = vq[k].rr;
            @(negedge clk);
            chk($sformatf("row%0d_req_ready", k), {28'h0, req_ready}, {28'h0, vq[k].e_ready});
            chk($sformatf("row%0d_pipe_input_valid", k), {31'h0, pipe_input_valid}, {31'h0, |vq[k].e_ready});
            chk($sformatf("row%0d_pipe_x", k), pipe_x, vq[k].e_px);
            chk($sformatf("row%0d_resp_valid", k), {31'h0, resp_valid}, {31'h0, vq[k].e_rvld});
            if (vq[k].e_rvld) begin
                chk($sformatf("row%0d_resp_id", k), {30'h0, resp_id}, {30'h0, vq[k].e_id});
                chk($sformatf("row%0d_resp_data", k), resp_data, vq[k].e_data);
            end
            if (vq[k].rst) begin
                chk($sformatf("row%0d_rst_resp_data", k), resp_data, 32'h0);
                chk($sformatf("row%0d_rst_resp_id", k), {30'h0, resp_id}, 32'h0);
                chk($sformatf("row%0d_rst_err", k), {31'h0, err_unexpected}, 32'h0);
                chk($sformatf("row%0d_rst_rr_ptr", k), {30'h0, dut.rr_ptr}, 32'h0);
            end
        end

        // Backpressure: with resp_ready low only FIFO_DEPTH issues get through.
        tick();
        req_valid  = 4'hF;
        resp_ready = 1'b0;
        issues     = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (pipe_input_valid) issues++;
            tick();
        end
        @(negedge clk);
        chk("bp_issue_count", issues, 32'd4);
        chk("bp_req_ready_blocked", {28'h0, req_ready}, 32'h0);
        chk("bp_fifo_count", {29'h0, dut.fifo_count}, 32'd4);
        tick();
        req_valid  = 4'h0;
        resp_ready = 1'b1;
        drained    = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                chk($sformatf("bp_drain%0d_id", drained), {30'h0, resp_id}, drained);
                chk($sformatf("bp_drain%0d_data", drained), resp_data, res[drained % 4]);
                drained++;
            end
            tick();
        end
        chk("bp_drain_count", drained, 32'd4);
        req_valid = 4'b0010;
        @(negedge clk);
        chk("bp_resume_ready", {28'h0, req_ready}, 32'h2);
        chk("bp_resume_pipe_x", pipe_x, X1);
        tick();
        req_valid = 4'h0;
        repeat (8) tick();

        // FIFO holding two entries sees a push and a pop on the same edge.
        resp_ready = 1'b0;
        req_valid  = 4'hF;
        tick();
        tick();
        tick();
        req_valid = 4'h0;
        tick();
        tick();
        resp_ready = 1'b1;
        @(negedge clk);
        chk("pp_count_before", {29'h0, dut.fifo_count}, 32'd2);
        chk("pp_push_same_cycle", {31'h0, pipe_output_valid}, 32'd1);
        tick();
        resp_ready = 1'b0;
        @(negedge clk);
        chk("pp_count_after", {29'h0, dut.fifo_count}, 32'd2);
        tick();
        resp_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("pp_drained", {31'h0, resp_valid}, 32'd0);

        // Unexpected result with nothing in flight: error sticks, nothing queued.
        tick();
        force_pov = 1'b1;
        tick();
        force_pov = 1'b0;
        @(negedge clk);
        chk("unexp_err_set", {31'h0, err_unexpected}, 32'd1);
        chk("unexp_no_push", {29'h0, dut.fifo_count}, 32'd0);
        repeat (3) tick();
        @(negedge clk);
        chk("unexp_err_sticky", {31'h0, err_unexpected}, 32'd1);
        chk("unexp_no_resp", {31'h0, resp_valid}, 32'd0);

        // Reset with three requests in flight: everything discarded.
        tick();
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        tick();
        tick();
        tick();
        req_valid = 4'h0;
        rst       = 1'b1;
        @(negedge clk);
        chk("mid_rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("mid_rst_req_ready", {28'h0, req_ready}, 32'd0);
        chk("mid_rst_err_clear", {31'h0, err_unexpected}, 32'd0);
        repeat (5) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rr_ptr", {30'h0, dut.rr_ptr}, 32'd0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("post_rst_no_responses", seen, 32'd0);
        chk("post_rst_err", {31'h0, err_unexpected}, 32'd0);
        tick();
        req_valid = 4'hF;
        @(negedge clk);
        chk("post_rst_first_grant", {28'h0, req_ready}, 32'h1);
        tick();
        req_valid = 4'h0;
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
